trap_sequencer: RTL and testbench

//  Commit-point trap controller for the RISC-X core. Arbitrates synchronous exceptions,
//  the machine external interrupt and MRET, then sequences the response: pipeline flush,
//  CSR save/restore, and PC redirect through the NPC_EXCEPTION / exc_pc_mux_t path.

---
 rtl/trap_sequencer.sv | 164 ++++++++++++++++
 tb/tb_trap_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Commit-point trap controller: arbitrates exception / external interrupt / MRET and
// sequences flush, CSR save or restore, and the PC redirect. All outputs are registered.
module trap_sequencer #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            exc_valid_i,
    input  logic [4:0]      exc_cause_i,
    input  logic [XLEN-1:0] exc_tval_i,
    input  logic [XLEN-1:0] commit_pc_i,
    input  logic            mret_i,
    input  logic            irq_ext_i,
    input  logic            mstatus_mie_i,
    input  logic            mie_meie_i,
    input  logic [XLEN-1:0] mtvec_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            flush_o,
    output logic            csr_save_o,
    output logic            csr_restore_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mcause_o,
    output logic [XLEN-1:0] mtval_o,
    output logic            pc_set_o,
    output logic            exc_pc_mux_o,
    output logic [XLEN-1:0] trap_target_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_SAVE,
        S_RESTORE,
        S_REDIRECT
    } state_t;

    localparam logic       EXCPC_MTVEC = 1'b0;
    localparam logic       EXCPC_MEPC  = 1'b1;
    localparam logic [2:0] FLUSH_LAST  = 3'(FLUSH_CYCLES);

    state_t            state_q;
    logic              trap_q;
    logic [2:0]        cnt_q;
    logic [XLEN-1:0]   mepc_q;
    logic [XLEN-1:0]   mcause_q;
    logic [XLEN-1:0]   mtval_q;
    logic              busy_q;
    logic              stall_q;
    logic              flush_q;
    logic              save_q;
    logic              restore_q;
    logic              pc_set_q;
    logic              mux_q;
    logic [XLEN-1:0]   target_q;
    logic              irq_take;

    // Vectored mode only offsets interrupts; the cause's interrupt bit shifts out.
    function automatic logic [XLEN-1:0] vector_target(input logic [XLEN-1:0] mtvec,
                                                      input logic [XLEN-1:0] mcause);
        logic [XLEN-1:0] base;
        base = {mtvec[XLEN-1:2], 2'b00};
        if (mtvec[1:0] == 2'b01 && mcause[XLEN-1])
            return base + {mcause[XLEN-3:0], 2'b00};
        return base;
    endfunction

    assign irq_take = irq_ext_i & mstatus_mie_i & mie_meie_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            trap_q    <= 1'b0;
            cnt_q     <= 3'd0;
            mepc_q    <= '0;
            mcause_q  <= '0;
            mtval_q   <= '0;
            busy_q    <= 1'b0;
            stall_q   <= 1'b0;
            flush_q   <= 1'b0;
            save_q    <= 1'b0;
            restore_q <= 1'b0;
            pc_set_q  <= 1'b0;
            mux_q     <= EXCPC_MTVEC;
            target_q  <= '0;
        end else begin
            save_q    <= 1'b0;
            restore_q <= 1'b0;
            pc_set_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (exc_valid_i || irq_take || mret_i) begin
                        state_q <= S_FLUSH;
                        cnt_q   <= 3'd1;
                        busy_q  <= 1'b1;
                        stall_q <= 1'b1;
                        flush_q <= 1'b1;
                    end
                    if (exc_valid_i) begin
                        trap_q   <= 1'b1;
                        mepc_q   <= commit_pc_i;
                        mcause_q <= {{(XLEN-5){1'b0}}, exc_cause_i};
                        mtval_q  <= exc_tval_i;
                    end else if (irq_take) begin
                        trap_q   <= 1'b1;
                        mepc_q   <= commit_pc_i;
                        mcause_q <= {1'b1, {(XLEN-5){1'b0}}, 4'hB};
                        mtval_q  <= '0;
                    end else if (mret_i) begin
                        trap_q <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (cnt_q == FLUSH_LAST) begin
                        flush_q <= 1'b0;
                        if (trap_q) begin
                            state_q <= S_SAVE;
                            save_q  <= 1'b1;
                        end else begin
                            state_q   <= S_RESTORE;
                            restore_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                S_SAVE, S_RESTORE: begin
                    // mtvec is taken here so the redirect sees it after the CSR update.
                    state_q  <= S_REDIRECT;
                    pc_set_q <= 1'b1;
                    mux_q    <= trap_q ? EXCPC_MTVEC : EXCPC_MEPC;
                    target_q <= trap_q ? vector_target(mtvec_i, mcause_q) : '0;
                end
                S_REDIRECT: begin
                    state_q  <= S_IDLE;
                    busy_q   <= 1'b0;
                    stall_q  <= 1'b0;
                    mux_q    <= EXCPC_MTVEC;
                    target_q <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    stall_q <= 1'b0;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign stall_o       = stall_q;
    assign flush_o       = flush_q;
    assign csr_save_o    = save_q;
    assign csr_restore_o = restore_q;
    assign mepc_o        = mepc_q;
    assign mcause_o      = mcause_q;
    assign mtval_o       = mtval_q;
    assign pc_set_o      = pc_set_q;
    assign exc_pc_mux_o  = mux_q;
    assign trap_target_o = target_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios plus randomized requests
// compared against a per-transaction reference model built from the latency rules.
module tb_trap_sequencer;

    localparam int F = 2;
    localparam logic MUX_MTVEC = 1'b0;
    localparam logic MUX_MEPC  = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid;
    logic [4:0]  exc_cause;
    logic [31:0] exc_tval;
    logic [31:0] commit_pc;
    logic        mret;
    logic        irq_ext;
    logic        mstatus_mie;
    logic        mie_meie;
    logic [31:0] mtvec;
    logic        busy, stall, flush, csr_save, csr_restore, pc_set, exc_pc_mux;
    logic [31:0] mepc, mcause, mtval, trap_target;

    int tests = 0;
    int fails = 0;

    trap_sequencer #(.XLEN(32), .FLUSH_CYCLES(F)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .exc_valid_i   (exc_valid),
        .exc_cause_i   (exc_cause),
        .exc_tval_i    (exc_tval),
        .commit_pc_i   (commit_pc),
        .mret_i        (mret),
        .irq_ext_i     (irq_ext),
        .mstatus_mie_i (mstatus_mie),
        .mie_meie_i    (mie_meie),
        .mtvec_i       (mtvec),
        .busy_o        (busy),
        .stall_o       (stall),
        .flush_o       (flush),
        .csr_save_o    (csr_save),
        .csr_restore_o (csr_restore),
        .mepc_o        (mepc),
        .mcause_o      (mcause),
        .mtval_o       (mtval),
        .pc_set_o      (pc_set),
        .exc_pc_mux_o  (exc_pc_mux),
        .trap_target_o (trap_target)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        exc_valid = 1'b0; exc_cause = 5'd0; exc_tval = 32'd0; commit_pc = 32'd0;
        mret = 1'b0; irq_ext = 1'b0; mstatus_mie = 1'b0; mie_meie = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".busy"},    32'(busy),        32'd0);
        chk({tag, ".stall"},   32'(stall),       32'd0);
        chk({tag, ".flush"},   32'(flush),       32'd0);
        chk({tag, ".save"},    32'(csr_save),    32'd0);
        chk({tag, ".restore"}, 32'(csr_restore), 32'd0);
        chk({tag, ".pc_set"},  32'(pc_set),      32'd0);
    endtask

    // Reference: 0 = nothing, 1 = trap, 2 = return; plus the expected CSR values.
    task automatic model(input logic e, input logic [4:0] c, input logic [31:0] tv,
                         input logic [31:0] pc, input logic m, input logic irq,
                         input logic mie, input logic meie, input logic [31:0] mtv,
                         output int kind, output logic [31:0] x_mepc,
                         output logic [31:0] x_mcause, output logic [31:0] x_mtval,
                         output logic [31:0] x_target);
        logic [31:0] base;
        kind = 0; x_mepc = 0; x_mcause = 0; x_mtval = 0;
        if (e) begin
            kind = 1; x_mepc = pc; x_mcause = 32'(c); x_mtval = tv;
        end else if (irq && mie && meie) begin
            kind = 1; x_mepc = pc; x_mcause = 32'h8000_000B; x_mtval = 0;
        end else if (m) begin
            kind = 2;
        end
        base = mtv & ~32'h3;
        if (mtv[1:0] == 2'b01 && x_mcause[31])
            x_target = base + ((x_mcause & 32'h7FFF_FFFF) << 2);
        else
            x_target = base;
    endtask

    // Caller is #1 past a rising edge with the sequencer idle.
    task automatic run_txn(input string tag, input logic e, input logic [4:0] c,
                           input logic [31:0] tv, input logic [31:0] pc, input logic m,
                           input logic irq, input logic mie, input logic meie,
                           input logic [31:0] mtv);
        int kind;
        logic [31:0] x_mepc, x_mcause, x_mtval, x_target;
        model(e, c, tv, pc, m, irq, mie, meie, mtv, kind, x_mepc, x_mcause, x_mtval, x_target);
        exc_valid = e; exc_cause = c; exc_tval = tv; commit_pc = pc; mret = m;
        irq_ext = irq; mstatus_mie = mie; mie_meie = meie; mtvec = mtv;
        next_cycle();
        if (kind == 0) begin
            clear_inputs();
            chk_quiet({tag, ".none"});
            return;
        end
        for (int k = 1; k <= F + 3; k++) begin
            chk($sformatf("%s.c%0d.busy", tag, k),    32'(busy),        32'(k <= F + 2));
            chk($sformatf("%s.c%0d.stall", tag, k),   32'(stall),       32'(k <= F + 2));
            chk($sformatf("%s.c%0d.flush", tag, k),   32'(flush),       32'(k <= F));
            chk($sformatf("%s.c%0d.save", tag, k),    32'(csr_save),    32'(kind == 1 && k == F + 1));
            chk($sformatf("%s.c%0d.restore", tag, k), 32'(csr_restore), 32'(kind == 2 && k == F + 1));
            chk($sformatf("%s.c%0d.pc_set", tag, k),  32'(pc_set),      32'(k == F + 2));
            if (csr_save) begin
                chk({tag, ".mepc"},   mepc,   x_mepc);
                chk({tag, ".mcause"}, mcause, x_mcause);
                chk({tag, ".mtval"},  mtval,  x_mtval);
            end
            if (pc_set) begin
                chk({tag, ".mux"}, 32'(exc_pc_mux), 32'(kind == 1 ? MUX_MTVEC : MUX_MEPC));
                if (kind == 1) chk({tag, ".target"}, trap_target, x_target);
            end
            // Requests arriving while busy must be ignored.
            if (k <= F + 1) begin
                exc_valid = 1'($urandom_range(0, 1)); exc_cause = 5'($urandom);
                exc_tval = $urandom; commit_pc = $urandom; mret = 1'($urandom_range(0, 1));
                irq_ext = 1'($urandom_range(0, 1)); mstatus_mie = 1'($urandom_range(0, 1));
                mie_meie = 1'($urandom_range(0, 1));
            end else begin
                clear_inputs();
            end
            next_cycle();
        end
    endtask

    initial begin
        rst = 1'b1;
        mtvec = 32'd0;
        clear_inputs();
        repeat (2) next_cycle();
        chk_quiet("reset");
        chk("reset.mepc",   mepc,        32'd0);
        chk("reset.mcause", mcause,      32'd0);
        chk("reset.mtval",  mtval,       32'd0);
        chk("reset.mux",    32'(exc_pc_mux), 32'd0);
        chk("reset.target", trap_target, 32'd0);
        rst = 1'b0;
        next_cycle();

        run_txn("illegal", 1'b1, 5'h02, 32'hFFFF_FFFF, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000);
        run_txn("vec_irq", 1'b0, 5'h00, 32'h0, 32'h200, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8001);

        irq_ext = 1'b1; mstatus_mie = 1'b0; mie_meie = 1'b1;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            chk_quiet($sformatf("masked.c%0d", i));
        end
        clear_inputs();
        next_cycle();

        run_txn("simult", 1'b1, 5'h0B, 32'h0, 32'h300, 1'b1, 1'b1, 1'b1, 1'b1, 32'h8001);
        run_txn("mret", 1'b0, 5'h00, 32'h0, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000);

        exc_valid = 1'b1; exc_cause = 5'h04; commit_pc = 32'h500; exc_tval = 32'h1234;
        next_cycle();
        chk("rstflush.flush", 32'(flush), 32'd1);
        rst = 1'b1; exc_valid = 1'b1; exc_cause = 5'h06; commit_pc = 32'h600;
        next_cycle();
        chk_quiet("rstflush.after");
        chk("rstflush.mepc", mepc, 32'd0);
        rst = 1'b0;
        clear_inputs();
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            chk_quiet($sformatf("rstflush.idle%0d", i));
        end

        for (int t = 0; t < 40; t++) begin
            logic [31:0] mtv;
            mtv = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00} | 32'($urandom_range(0, 3));
            run_txn($sformatf("rnd%0d", t), 1'($urandom_range(0, 3) == 0), 5'($urandom),
                    $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mtv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
